qed_dup_issuer: RTL and testbench

- Issue-side counterpart of the SQED instruction constraint. The constraint checks that original instructions use only x0-x15 and the lower memory half; this block produces the matching duplicate stream.
- Sits between the symbolic instruction source and the core fetch port.
- Passes originals through and queues them. On request, it replays each queued original as its duplicate: registers remapped to x16-x31 and memory offset into the upper half.
- Tracks original and duplicate counts and flags when the two streams are in lock-step, which is the consistency-check point.

---
 rtl/qed_dup_issuer.sv | 171 +++++++++++++++++
 tb/tb_qed_dup_issuer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/qed_dup_issuer.sv
// Issue-side SQED duplicate generator: forwards constrained originals to the core,
// queues them, and on request replays each as its register/memory-remapped duplicate.
module qed_dup_issuer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      ifu_instruction,
  input  logic             exec_dup,
  input  logic             stall,
  output logic [31:0]      qed_instruction,
  output logic             qed_is_dup,
  output logic             qed_vld,
  output logic             queue_full,
  output logic [CNT_W-1:0] num_orig,
  output logic [CNT_W-1:0] num_dup,
  output logic             qed_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [6:0]       OP_NOP    = 7'b1111111;
  localparam logic [6:0]       OP_R      = 7'b0110011;
  localparam logic [6:0]       OP_I      = 7'b0010011;
  localparam logic [6:0]       OP_LW     = 7'b0000011;
  localparam logic [6:0]       OP_SW     = 7'b0100011;
  localparam logic [31:0]      NOP_INSTR = 32'h0000_007F;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [PTR_W:0]   OCC_FULL  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   OCC_ONE   = (PTR_W+1)'(1);

  // Original-instruction queue storage and bookkeeping.
  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   occ_q, occ_d;

  logic [31:0]      instr_q, instr_d;
  logic             is_dup_q, is_dup_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] orig_q, orig_d;
  logic [CNT_W-1:0] dup_q, dup_d;
  logic             ready_q, ready_d;

  logic        full_w;
  logic        in_nop;
  logic        do_pop;
  logic        do_push;
  logic [31:0] head_w;
  logic [31:0] dup_w;

  // Duplicate remap: bit 4 of each register field moves x0-x15 into x16-x31;
  // bit 30 of a load/store immediate adds 1024, landing in the upper memory half.
  function automatic logic [31:0] dup_xform(input logic [31:0] i);
    logic [31:0] o;
    o = i;
    case (i[6:0])
      OP_R: begin
        o[11] = 1'b1;
        o[19] = 1'b1;
        o[24] = 1'b1;
      end
      OP_I: begin
        o[11] = 1'b1;
        o[19] = 1'b1;
      end
      OP_LW: begin
        o[11] = 1'b1;
        o[30] = 1'b1;
      end
      OP_SW: begin
        o[24] = 1'b1;
        o[30] = 1'b1;
      end
      default: o = i;
    endcase
    return o;
  endfunction

  assign full_w = (occ_q == OCC_FULL);
  assign in_nop = (ifu_instruction[6:0] == OP_NOP);
  assign head_w = mem_q[rd_ptr_q];
  assign dup_w  = dup_xform(head_w);

  // stall is the core's not-ready: while high nothing is consumed or produced and
  // every register holds; with stall low the issued word is taken on the edge.
  assign do_pop  = !stall && exec_dup && (occ_q != '0);
  assign do_push = !stall && !do_pop && !in_nop && !full_w;

  always_comb begin
    instr_d  = instr_q;
    is_dup_d = is_dup_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    orig_d   = orig_q;
    dup_d    = dup_q;
    ready_d  = ready_q;

    if (!stall) begin
      if (do_pop) begin
        instr_d  = dup_w;
        is_dup_d = 1'b1;
        vld_d    = 1'b1;
        rd_ptr_d = rd_ptr_q + 1'b1;
        occ_d    = occ_q - OCC_ONE;
        dup_d    = (dup_q == CNT_MAX) ? dup_q : dup_q + 1'b1;
      end else if (in_nop) begin
        instr_d  = ifu_instruction;
        is_dup_d = 1'b0;
        vld_d    = 1'b0;
      end else if (full_w) begin
        instr_d  = NOP_INSTR;
        is_dup_d = 1'b0;
        vld_d    = 1'b0;
      end else begin
        instr_d  = ifu_instruction;
        is_dup_d = 1'b0;
        vld_d    = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        occ_d    = occ_q + OCC_ONE;
        orig_d   = (orig_q == CNT_MAX) ? orig_q : orig_q + 1'b1;
      end

      // Lock-step flag tracks the new counts; a saturated counter can no longer be trusted.
      ready_d = (orig_d == dup_d) && (orig_d != '0) &&
                (orig_d != CNT_MAX) && (dup_d != CNT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= ifu_instruction;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q  <= NOP_INSTR;
      is_dup_q <= 1'b0;
      vld_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      orig_q   <= '0;
      dup_q    <= '0;
      ready_q  <= 1'b0;
    end else begin
      instr_q  <= instr_d;
      is_dup_q <= is_dup_d;
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      orig_q   <= orig_d;
      dup_q    <= dup_d;
      ready_q  <= ready_d;
    end
  end

  assign qed_instruction = instr_q;
  assign qed_is_dup      = is_dup_q;
  assign qed_vld         = vld_q;
  assign queue_full      = full_w;
  assign num_orig        = orig_q;
  assign num_dup         = dup_q;
  assign qed_ready       = ready_q;

endmodule

// File: tb/tb_qed_dup_issuer.sv
// Directed bench for qed_dup_issuer: pass-through, duplicate remap, queue-full,
// stall hold, counter saturation and asynchronous reset.
module tb_qed_dup_issuer;

  localparam int DEPTH = 8;
  localparam int CNT_W = 8;

  localparam logic [31:0] NOP     = 32'h0000_007F;
  localparam logic [31:0] ADD     = 32'h0031_00B3;  // ADD x1,x2,x3
  localparam logic [31:0] ADD_D   = 32'h0139_08B3;  // ADD x17,x18,x19
  localparam logic [31:0] LW      = 32'h0040_2283;  // LW x5,4(x0)
  localparam logic [31:0] LW_D    = 32'h4040_2A83;  // LW x21,1028(x0)
  localparam logic [31:0] SW      = 32'h0070_2423;  // SW x7,8(x0)
  localparam logic [31:0] SW_D    = 32'h4170_2423;  // SW x23,1032(x0)
  localparam logic [31:0] ADDI    = 32'h0051_0093;  // ADDI x1,x2,5
  localparam logic [31:0] ADDI_D  = 32'h0059_0893;  // ADDI x17,x18,5
  localparam logic [31:0] LUI     = 32'h1234_50B7;  // LUI: other opcode, unchanged
  localparam logic [31:0] ODD_NOP = 32'h1234_567F;

  logic             clk;
  logic             rst_n;
  logic [31:0]      ifu_instruction;
  logic             exec_dup;
  logic             stall;
  logic [31:0]      qed_instruction;
  logic             qed_is_dup;
  logic             qed_vld;
  logic             queue_full;
  logic [CNT_W-1:0] num_orig;
  logic [CNT_W-1:0] num_dup;
  logic             qed_ready;

  int n_cmp;
  int n_err;
  logic [31:0] exp_q[$];
  logic [31:0] v;

  qed_dup_issuer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ifu_instruction (ifu_instruction),
    .exec_dup        (exec_dup),
    .stall           (stall),
    .qed_instruction (qed_instruction),
    .qed_is_dup      (qed_is_dup),
    .qed_vld         (qed_vld),
    .queue_full      (queue_full),
    .num_orig        (num_orig),
    .num_dup         (num_dup),
    .qed_ready       (qed_ready)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic dup, input logic stl);
    ifu_instruction = instr;
    exec_dup        = dup;
    stall           = stl;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    ifu_instruction = NOP;
    exec_dup = 1'b0;
    stall = 1'b0;

    #12;
    check("rst_instr", qed_instruction, NOP);
    check("rst_is_dup", 32'(qed_is_dup), 32'd0);
    check("rst_vld", 32'(qed_vld), 32'd0);
    check("rst_full", 32'(queue_full), 32'd0);
    check("rst_orig", 32'(num_orig), 32'd0);
    check("rst_dup", 32'(num_dup), 32'd0);
    check("rst_ready", 32'(qed_ready), 32'd0);
    rst_n = 1'b1;

    // ADD original, then its duplicate
    drive(ADD, 1'b0, 1'b0);
    check("add_instr", qed_instruction, ADD);
    check("add_vld", 32'(qed_vld), 32'd1);
    check("add_is_dup", 32'(qed_is_dup), 32'd0);
    check("add_orig", 32'(num_orig), 32'd1);
    check("add_ready", 32'(qed_ready), 32'd0);

    drive(ADD, 1'b1, 1'b0);
    check("addd_instr", qed_instruction, ADD_D);
    check("addd_is_dup", 32'(qed_is_dup), 32'd1);
    check("addd_vld", 32'(qed_vld), 32'd1);
    check("addd_orig", 32'(num_orig), 32'd1);
    check("addd_dup", 32'(num_dup), 32'd1);
    check("addd_ready", 32'(qed_ready), 32'd1);

    drive(LW, 1'b0, 1'b0);
    check("lw_instr", qed_instruction, LW);
    check("lw_ready", 32'(qed_ready), 32'd0);
    drive(LW, 1'b1, 1'b0);
    check("lwd_instr", qed_instruction, LW_D);
    check("lwd_dup", 32'(num_dup), 32'd2);

    drive(SW, 1'b0, 1'b0);
    check("sw_instr", qed_instruction, SW);
    drive(SW, 1'b1, 1'b0);
    check("swd_instr", qed_instruction, SW_D);
    check("swd_orig", 32'(num_orig), 32'd3);
    check("swd_dup", 32'(num_dup), 32'd3);
    check("swd_ready", 32'(qed_ready), 32'd1);

    // exec_dup on empty queue with a NOP-opcode input: passed through unchanged
    drive(ODD_NOP, 1'b1, 1'b0);
    check("empty_instr", qed_instruction, ODD_NOP);
    check("empty_vld", 32'(qed_vld), 32'd0);
    check("empty_is_dup", 32'(qed_is_dup), 32'd0);
    check("empty_orig", 32'(num_orig), 32'd3);
    check("empty_dup", 32'(num_dup), 32'd3);

    // I-type and other-opcode originals, then a 3-cycle stall with a pending pop
    drive(ADDI, 1'b0, 1'b0);
    drive(LUI, 1'b0, 1'b0);
    check("lui_instr", qed_instruction, LUI);
    check("lui_orig", 32'(num_orig), 32'd5);
    for (int s = 0; s < 3; s++) begin
      drive(ADD, 1'b1, 1'b1);
      check("stall_instr", qed_instruction, LUI);
      check("stall_vld", 32'(qed_vld), 32'd1);
      check("stall_is_dup", 32'(qed_is_dup), 32'd0);
      check("stall_orig", 32'(num_orig), 32'd5);
      check("stall_dup", 32'(num_dup), 32'd3);
      check("stall_ready", 32'(qed_ready), 32'd0);
    end
    drive(ADD, 1'b1, 1'b0);
    check("addid_instr", qed_instruction, ADDI_D);
    drive(ADD, 1'b1, 1'b0);
    check("luid_instr", qed_instruction, LUI);
    check("luid_is_dup", 32'(qed_is_dup), 32'd1);
    check("luid_dup", 32'(num_dup), 32'd5);
    check("luid_ready", 32'(qed_ready), 32'd1);

    // Fill the queue with DEPTH R-type originals
    for (int i = 0; i < DEPTH; i++) begin
      v = {7'd0, 5'(i + 2), 5'(i + 1), 3'(i), 5'(i), 7'b0110011};
      exp_q.push_back(v | 32'h0108_0800);
      drive(v, 1'b0, 1'b0);
      check("fill_instr", qed_instruction, v);
      check("fill_full", 32'(queue_full), (i == DEPTH - 1) ? 32'd1 : 32'd0);
    end
    check("fill_orig", 32'(num_orig), 32'd13);

    drive(ADD, 1'b0, 1'b0);
    check("full_instr", qed_instruction, NOP);
    check("full_vld", 32'(qed_vld), 32'd0);
    check("full_orig", 32'(num_orig), 32'd13);
    check("full_flag", 32'(queue_full), 32'd1);

    for (int i = 0; i < DEPTH; i++) begin
      drive(ADD, 1'b1, 1'b0);
      v = exp_q.pop_front();
      check("drain_instr", qed_instruction, v);
      check("drain_is_dup", 32'(qed_is_dup), 32'd1);
    end
    check("drain_full", 32'(queue_full), 32'd0);
    check("drain_dup", 32'(num_dup), 32'd13);
    check("drain_ready", 32'(qed_ready), 32'd1);

    // Walk both counters up to saturation
    for (int k = 0; k < 242; k++) begin
      drive(ADD, 1'b0, 1'b0);
      drive(ADD, 1'b1, 1'b0);
      check("sat_pair_instr", qed_instruction, ADD_D);
      if (k == 240) check("sat_254_ready", 32'(qed_ready), 32'd1);
    end
    check("sat_orig", 32'(num_orig), 32'd255);
    check("sat_dup", 32'(num_dup), 32'd255);
    check("sat_ready", 32'(qed_ready), 32'd0);
    drive(ADD, 1'b0, 1'b0);
    check("sat_push_instr", qed_instruction, ADD);
    check("sat_push_vld", 32'(qed_vld), 32'd1);
    check("sat_push_orig", 32'(num_orig), 32'd255);
    check("sat_push_ready", 32'(qed_ready), 32'd0);

    // Asynchronous reset with three queued originals
    drive(LW, 1'b0, 1'b0);
    drive(SW, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_instr", qed_instruction, NOP);
    check("arst_vld", 32'(qed_vld), 32'd0);
    check("arst_orig", 32'(num_orig), 32'd0);
    check("arst_dup", 32'(num_dup), 32'd0);
    check("arst_ready", 32'(qed_ready), 32'd0);
    #1;
    rst_n = 1'b1;
    drive(ADD, 1'b1, 1'b0);
    check("post_instr", qed_instruction, ADD);
    check("post_is_dup", 32'(qed_is_dup), 32'd0);
    check("post_orig", 32'(num_orig), 32'd1);
    check("post_dup", 32'(num_dup), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
